q_max_scan_arbiter: RTL and testbench

Sequential, shared max-Q lookup engine for the maze-solver Q-learning core. Two requesters (policy/action selection and learner/next-state bootstrap) each request the maximum Q-value over all actions of a given state. The block arbitrates round-robin between them, streams that state's action row out of the single-port Q-table RAM one word per cycle, and keeps a running max and argmax. It returns the result with a done pulse tagged by requester ID.

---
 rtl/q_max_scan_arbiter.sv | 133 +++++++++++++
 tb/tb_q_max_scan_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/q_max_scan_arbiter.sv
// Shared max-Q lookup engine: round-robin between two requesters, streams one
// state's action row from the Q-table RAM and returns the max value and argmax.
module q_max_scan_arbiter #(
    parameter int NUM_ACT = 15,
    parameter int DATA_W  = 16,
    parameter int STATE_W = 8,
    parameter int ACT_W   = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [1:0]               i_req,
    input  logic [STATE_W-1:0]       i_state0,
    input  logic [STATE_W-1:0]       i_state1,
    output logic [1:0]               o_grant,
    output logic                     o_busy,
    output logic                     o_ram_rd_en,
    output logic [STATE_W+ACT_W-1:0] o_ram_addr,
    input  logic [DATA_W-1:0]        i_ram_rd_data,
    output logic                     o_done,
    output logic                     o_done_id,
    output logic [DATA_W-1:0]        o_max_q,
    output logic [ACT_W-1:0]         o_max_act,
    output logic [1:0]               o_dbg_state
);

    // Handshake: i_req[n] is a level held until a done with o_done_id==n;
    // the requester may drop it in the done cycle to avoid a re-grant.
    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

    localparam logic [ACT_W-1:0] K_LAST = ACT_W'(NUM_ACT - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [STATE_W-1:0]  r_st;
    logic                r_id;
    logic                r_last_id;
    logic [ACT_W-1:0]    r_k;
    logic                r_cap_vld;
    logic [ACT_W-1:0]    r_cap_k;
    logic [DATA_W-1:0]   r_run_max;
    logic [ACT_W-1:0]    r_run_act;
    logic [DATA_W-1:0]   r_max_q;
    logic [ACT_W-1:0]    r_max_act;
    logic                w_arb;
    logic                w_win;
    logic                w_take;
    logic [DATA_W-1:0]   w_new_max;
    logic [ACT_W-1:0]    w_new_act;

    always_comb begin
        w_win = 1'b0;
        case (i_req)
            2'b10:   w_win = 1'b1;
            2'b11:   w_win = ~r_last_id;
            default: w_win = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_arb       = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (i_req != 2'b00) begin
                    w_state_nxt = S_SCAN;
                    w_arb       = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SCAN:  if (r_k == K_LAST) w_state_nxt = S_DRAIN;
            S_DRAIN: w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Action 0 always loads; later words need a strict win so ties keep the lowest index.
    always_comb begin
        w_take    = r_cap_vld && ((r_cap_k == '0) || (i_ram_rd_data > r_run_max));
        w_new_max = w_take ? i_ram_rd_data : r_run_max;
        w_new_act = w_take ? r_cap_k : r_run_act;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_st      <= '0;
            r_id      <= 1'b0;
            r_last_id <= 1'b1;
            r_k       <= '0;
            r_cap_vld <= 1'b0;
            r_cap_k   <= '0;
            r_run_max <= '0;
            r_run_act <= '0;
            r_max_q   <= '0;
            r_max_act <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_arb) begin
                r_st      <= w_win ? i_state1 : i_state0;
                r_id      <= w_win;
                r_last_id <= w_win;
                r_k       <= '0;
            end else if (r_state == S_SCAN) begin
                r_k <= r_k + ACT_W'(1);
            end
            r_cap_vld <= (r_state == S_SCAN);
            r_cap_k   <= r_k;
            r_run_max <= w_new_max;
            r_run_act <= w_new_act;
            // DRAIN captures the last word, so publish the post-capture value.
            if (r_state == S_DRAIN) begin
                r_max_q   <= w_new_max;
                r_max_act <= w_new_act;
            end
        end
    end

    always_comb begin
        o_busy      = (r_state == S_SCAN) || (r_state == S_DRAIN);
        o_ram_rd_en = (r_state == S_SCAN);
        o_ram_addr  = (r_state == S_SCAN) ? {r_st, r_k} : '0;
        o_grant     = '0;
        if ((r_state == S_SCAN) && (r_k == '0))
            o_grant = r_id ? 2'b10 : 2'b01;
        o_done      = (r_state == S_DONE);
        o_done_id   = (r_state == S_DONE) && r_id;
        o_max_q     = r_max_q;
        o_max_act   = r_max_act;
        o_dbg_state = r_state;
    end

endmodule

// File: tb/tb_q_max_scan_arbiter.sv
// Directed bench for q_max_scan_arbiter with a synchronous Q-table RAM model.
module tb_q_max_scan_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req;
    logic [7:0]  state0, state1;
    logic [1:0]  grant;
    logic        busy, ram_rd_en, done, done_id;
    logic [11:0] ram_addr;
    logic [15:0] ram_rd_data = '0;
    logic [15:0] max_q;
    logic [3:0]  max_act;
    logic [1:0]  dbg_state;

    q_max_scan_arbiter dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req),
        .i_state0(state0), .i_state1(state1),
        .o_grant(grant), .o_busy(busy), .o_ram_rd_en(ram_rd_en),
        .o_ram_addr(ram_addr), .i_ram_rd_data(ram_rd_data),
        .o_done(done), .o_done_id(done_id), .o_max_q(max_q),
        .o_max_act(max_act), .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] mem [0:4095];
    always @(posedge clk) if (ram_rd_en) ram_rd_data <= mem[ram_addr];

    int n_chk = 0;
    int n_fail = 0;

    logic [1:0]  g_val_q[$];
    int          g_cyc_q[$];
    logic        d_id_q[$];
    logic [15:0] d_max_q[$];
    logic [3:0]  d_act_q[$];
    int          d_cyc_q[$];
    logic [11:0] rd_q[$];
    logic [15:0] exp_q[$];
    int          addr_viol = 0;

    always @(negedge clk) begin
        if (grant != 2'b00) begin
            g_val_q.push_back(grant);
            g_cyc_q.push_back(cyc);
        end
        if (done) begin
            d_id_q.push_back(done_id);
            d_max_q.push_back(max_q);
            d_act_q.push_back(max_act);
            d_cyc_q.push_back(cyc);
        end
        if (ram_rd_en) rd_q.push_back(ram_addr);
        else if (ram_addr != 12'h000) addr_viol++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        g_val_q.delete(); g_cyc_q.delete(); d_id_q.delete(); d_max_q.delete();
        d_act_q.delete(); d_cyc_q.delete(); rd_q.delete();
    endtask

    // Waits for n done pulses; drops the req bits in clr during the last one.
    task automatic wait_dones(input string tag, input int n, input logic [1:0] clr, input int limit);
        int seen = 0;
        int t = 0;
        while (seen < n && t < limit) begin
            @(negedge clk);
            t++;
            if (done) begin
                seen++;
                if (seen == n) req = req & ~clr;
            end
        end
        chk({tag, "_done_count"}, seen, n);
    endtask

    task automatic check_done(input string tag, input int idx, input int c0, input int off,
                              input logic id, input logic [3:0] act);
        chk({tag, "_done_cycle"}, d_cyc_q[idx] - c0, off);
        chk({tag, "_done_id"}, d_id_q[idx], id);
        chk({tag, "_max_q"}, d_max_q[idx], exp_q.pop_front());
        chk({tag, "_max_act"}, d_act_q[idx], act);
    endtask

    task automatic run_single(input string tag, input logic [7:0] s,
                              input logic [15:0] eq, input logic [3:0] ea);
        int c0;
        next_cycle();
        clear_q();
        c0 = cyc;
        state0 = s;
        req = 2'b01;
        exp_q.push_back(eq);
        wait_dones(tag, 1, 2'b01, 40);
        next_cycle();
        chk({tag, "_reads"}, rd_q.size(), 15);
        check_done(tag, 0, c0, 17, 1'b0, ea);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_grant"}, grant, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_rd_en"}, ram_rd_en, 0);
        chk({tag, "_addr"}, ram_addr, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_done_id"}, done_id, 0);
        chk({tag, "_max_q"}, max_q, 0);
        chk({tag, "_max_act"}, max_act, 0);
    endtask

    initial begin
        int c0;
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
        for (int a = 0; a < 15; a++) begin
            mem[{8'h03, 4'(a)}] = 16'h0100 + 16'(a);
            mem[{8'h05, 4'(a)}] = (a == 5 || a == 9) ? 16'h7FFF : 16'h0040;
            mem[{8'h06, 4'(a)}] = (a == 0) ? 16'hFFFF : 16'h8000;
            mem[{8'h10, 4'(a)}] = 16'h0200 + 16'(a);
            mem[{8'h11, 4'(a)}] = 16'h0300 - 16'(a);
            mem[{8'h20, 4'(a)}] = (a == 7) ? 16'h0450 : 16'h0400;
        end

        rst_n = 1'b0; req = 2'b00; state0 = '0; state1 = '0;
        #1;
        check_all_zero("reset");
        chk("reset_fsm", dbg_state, 0);
        repeat (2) next_cycle();
        rst_n = 1'b1;

        // Single requester, ascending row.
        next_cycle();
        clear_q();
        c0 = cyc;
        state0 = 8'h03;
        req = 2'b01;
        exp_q.push_back(16'h010E);
        wait_dones("single", 1, 2'b01, 40);
        next_cycle();
        chk("single_grant_cnt", g_val_q.size(), 1);
        chk("single_grant", g_val_q[0], 2'b01);
        chk("single_grant_cycle", g_cyc_q[0] - c0, 1);
        check_done("single", 0, c0, 17, 1'b0, 4'd14);
        chk("single_reads", rd_q.size(), 15);
        chk("single_first_addr", rd_q[0], 12'h030);
        chk("single_last_addr", rd_q[14], 12'h03E);
        repeat (3) next_cycle();
        chk("single_idle_busy", busy, 0);
        chk("single_hold_max", max_q, 16'h010E);
        chk("single_hold_act", max_act, 4'd14);

        run_single("ties", 8'h05, 16'h7FFF, 4'd5);
        run_single("unsigned", 8'h06, 16'hFFFF, 4'd0);
        run_single("zeros", 8'h07, 16'h0000, 4'd0);

        // Both requesting straight out of reset.
        rst_n = 1'b0;
        repeat (2) next_cycle();
        rst_n = 1'b1;
        next_cycle();
        clear_q();
        c0 = cyc;
        state0 = 8'h10;
        state1 = 8'h11;
        req = 2'b11;
        exp_q.push_back(16'h020E);
        exp_q.push_back(16'h0300);
        exp_q.push_back(16'h020E);
        wait_dones("rr", 3, 2'b11, 80);
        next_cycle();
        chk("rr_grant_cnt", g_val_q.size(), 3);
        chk("rr_grant0", g_val_q[0], 2'b01);
        chk("rr_grant1", g_val_q[1], 2'b10);
        chk("rr_grant2", g_val_q[2], 2'b01);
        chk("rr_grant1_cycle", g_cyc_q[1] - c0, 18);
        chk("rr_grant2_cycle", g_cyc_q[2] - c0, 35);
        check_done("rr0", 0, c0, 17, 1'b0, 4'd14);
        check_done("rr1", 1, c0, 34, 1'b1, 4'd0);
        check_done("rr2", 2, c0, 51, 1'b0, 4'd14);
        chk("rr_reads", rd_q.size(), 45);

        // Lone requester 1 drops req mid-scan.
        next_cycle();
        clear_q();
        c0 = cyc;
        state1 = 8'h20;
        req = 2'b10;
        exp_q.push_back(16'h0450);
        repeat (5) next_cycle();
        req = 2'b00;
        state1 = 8'h05;
        wait_dones("drop", 1, 2'b00, 40);
        next_cycle();
        chk("drop_grant", g_val_q[0], 2'b10);
        check_done("drop", 0, c0, 17, 1'b1, 4'd7);
        chk("drop_first_addr", rd_q[0], 12'h200);

        // Asynchronous reset in the middle of a scan.
        next_cycle();
        clear_q();
        state0 = 8'h03;
        req = 2'b01;
        repeat (8) next_cycle();
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        repeat (3) next_cycle();
        chk("abort_no_done", d_cyc_q.size(), 0);
        clear_q();
        c0 = cyc;
        rst_n = 1'b1;
        exp_q.push_back(16'h010E);
        wait_dones("restart", 1, 2'b01, 40);
        next_cycle();
        chk("restart_grant", g_val_q[0], 2'b01);
        chk("restart_grant_cycle", g_cyc_q[0] - c0, 1);
        check_done("restart", 0, c0, 17, 1'b0, 4'd14);
        chk("restart_reads", rd_q.size(), 15);
        chk("restart_first_addr", rd_q[0], 12'h030);

        chk("addr_zero_when_idle", addr_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
